// File: rtl/ex_div_pkg.sv
// Shared encodings for the EX-stage iterative divider.
// Imported by the divider top and its datapath.
package ex_div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [31:0] DIV_MIN_NEG = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } div_state_e;

endpackage

// File: rtl/ex_div_core.sv
// Restoring shift/subtract datapath, one quotient bit per step.
// Operates on magnitudes only; signs are handled by the caller.
module ex_div_core
    import ex_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);

    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] div_q;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic            fits;

    // Shifted remainder needs XLEN+1 bits since it can reach 2*divisor-1.
    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        trial  = rem_sh - {1'b0, div_q};
        fits   = ~trial[XLEN];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            div_q <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            div_q <= divisor;
        end else if (step) begin
            quo_q <= {quo_q[XLEN-2:0], fits};
            rem_q <= fits ? trial[XLEN-1:0]
                          : rem_sh[XLEN-1:0];
        end
    end

    assign quo = quo_q;
    assign rem = rem_q;

endmodule

// File: rtl/ex_div_unit.sv
// EX-stage RV32M divider: FSM, special cases and sign fix-up.
// Stalls the front of the pipe while the core iterates.
module ex_div_unit
    import ex_div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    div_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic            is_rem_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic [4:0]      rd_q;

    logic            is_signed;
    logic            is_rem;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic            accept;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN-1:0] spec_res;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    always_comb begin
        is_signed = (op == OP_DIV) || (op == OP_REM);
        is_rem    = (op == OP_REM) || (op == OP_REMU);
        a_neg     = is_signed & opA[XLEN-1];
        b_neg     = is_signed & opB[XLEN-1];
        a_abs     = a_neg ? -opA : opA;
        b_abs     = b_neg ? -opB : opB;
        div_zero  = (opB == '0);
        div_ovf   = is_signed
                  & (opA == DIV_MIN_NEG[XLEN-1:0])
                  & (opB == '1);
        special   = div_zero | div_ovf;
        accept    = (state == ST_IDLE) & start & ~flush;
        // Divide-by-zero wins over overflow; both bypass the iteration.
        if (div_zero)
            spec_res = is_rem ? opA : '1;
        else
            spec_res = is_rem ? '0 : DIV_MIN_NEG[XLEN-1:0];
        quo_fix   = q_neg_q ? -quo : quo;
        rem_fix   = r_neg_q ? -rem : rem;
    end

    ex_div_core #(
        .XLEN     (XLEN)
    ) u_core (
        .clock    (clock),
        .reset    (reset),
        .load     (accept & ~special),
        .step     (state == ST_CALC),
        .dividend (a_abs),
        .divisor  (b_abs),
        .quo      (quo),
        .rem      (rem)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            rd_q     <= '0;
            done     <= 1'b0;
            result   <= '0;
            rd_out   <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start) begin
                            is_rem_q <= is_rem;
                            q_neg_q  <= a_neg ^ b_neg;
                            r_neg_q  <= a_neg;
                            rd_q     <= rd_in;
                            if (special) begin
                                result <= spec_res;
                                rd_out <= rd_in;
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end else begin
                                cnt    <= CNT_W'(XLEN);
                                state  <= ST_CALC;
                            end
                        end
                    end
                    ST_CALC: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1))
                            state <= ST_FIX;
                    end
                    ST_FIX: begin
                        result <= is_rem_q ? rem_fix : quo_fix;
                        rd_out <= rd_q;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy  = (state != ST_IDLE);
    assign stall = accept
                 | (state == ST_CALC)
                 | (state == ST_FIX);

endmodule
